// File: rtl/exp_seq_pkg.sv
// Shared constants and types for the exponentiation operand sequencer.
// Operand selectors, stream geometry, FSM states and go-request masks.
package exp_seq_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned OP_W    = 512;
  localparam int unsigned WORDS   = OP_W / WORD_W;
  localparam int unsigned CNT_W   = $clog2(WORDS);
  localparam int unsigned NUM_OPS = 5;

  localparam logic [2:0] SEL_MOD = 3'd0;
  localparam logic [2:0] SEL_RM  = 3'd1;
  localparam logic [2:0] SEL_R2  = 3'd2;
  localparam logic [2:0] SEL_EXP = 3'd3;
  localparam logic [2:0] SEL_X   = 3'd4;

  // Bit index in the masks equals the operand selector.
  localparam logic [NUM_OPS-1:0] MASK_MULT = 5'b10101;
  localparam logic [NUM_OPS-1:0] MASK_EXP  = 5'b11111;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDrain
  } state_e;

endpackage

// File: rtl/operand_word_reg.sv
// Wide operand register with a single indexed word write port.
module operand_word_reg
  import exp_seq_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              we_i,
  input  logic [CNT_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [OP_W-1:0]   q_o
);

  logic [OP_W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q[idx_i*WORD_W +: WORD_W] <= data_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/exp_operand_sequencer.sv
// Loads Montgomery exponentiation operands from a word stream, launches the core
// and streams the 512-bit result back out LS word first.
module exp_operand_sequencer
  import exp_seq_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        in_sel_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              go_i,
  input  logic              go_mult_i,
  output logic              go_err_o,
  output logic              busy_o,
  output logic [NUM_OPS-1:0] loaded_o,
  output logic              exp_start_o,
  output logic              exp_mult_o,
  output logic [OP_W-1:0]   exp_modulus_o,
  output logic [OP_W-1:0]   exp_rmodm_o,
  output logic [OP_W-1:0]   exp_r2modm_o,
  output logic [OP_W-1:0]   exp_exponent_o,
  output logic [OP_W-1:0]   exp_x_o,
  input  logic              exp_done_i,
  input  logic [OP_W-1:0]   exp_result_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_last_o
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           cur_sel_q, cur_sel_d;
  logic [NUM_OPS-1:0]   loaded_q, loaded_d;
  logic                 exp_mult_q, exp_mult_d;
  logic                 go_err_q, go_err_d;
  logic [OP_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]     beat_q, beat_d;

  logic [NUM_OPS-1:0]   op_we;
  logic [CNT_W-1:0]     widx;
  logic [NUM_OPS-1:0]   req_mask;
  logic                 beat_acc;
  logic                 sel_legal;
  logic                 restart;
  logic [OP_W-1:0]      op_q [NUM_OPS];

  assign in_ready_o = (state_q == StIdle) && resetn;
  assign beat_acc   = in_valid_i && in_ready_o;
  assign sel_legal  = (in_sel_i <= SEL_X);
  // A different selector before the current operand is complete abandons it.
  assign restart    = (cnt_q != '0) && (in_sel_i != cur_sel_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_sel_d  = cur_sel_q;
    loaded_d   = loaded_q;
    exp_mult_d = exp_mult_q;
    go_err_d   = 1'b0;
    shift_d    = shift_q;
    beat_d     = beat_q;
    op_we      = '0;
    widx       = cnt_q;
    req_mask   = go_mult_i ? MASK_MULT : MASK_EXP;

    if (beat_acc && sel_legal) begin
      widx            = restart ? '0 : cnt_q;
      op_we[in_sel_i] = 1'b1;
      if (restart) begin
        loaded_d[cur_sel_q] = 1'b0;
      end
      if (widx == '0) begin
        loaded_d[in_sel_i] = 1'b0;
        cur_sel_d          = in_sel_i;
      end
      if (widx == CNT_W'(WORDS - 1)) begin
        loaded_d[in_sel_i] = 1'b1;
        cnt_d              = '0;
      end else begin
        cnt_d = widx + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          if ((loaded_q & req_mask) == req_mask) begin
            exp_mult_d = go_mult_i;
            state_d    = StStart;
          end else begin
            go_err_d = 1'b1;
          end
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (exp_done_i) begin
          shift_d = exp_result_i;
          beat_d  = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_ready_i) begin
          shift_d = shift_q >> WORD_W;
          beat_d  = beat_q + 1'b1;
          if (beat_q == CNT_W'(WORDS - 1)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cur_sel_q  <= SEL_MOD;
      loaded_q   <= '0;
      exp_mult_q <= 1'b0;
      go_err_q   <= 1'b0;
      shift_q    <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_sel_q  <= cur_sel_d;
      loaded_q   <= loaded_d;
      exp_mult_q <= exp_mult_d;
      go_err_q   <= go_err_d;
      shift_q    <= shift_d;
      beat_q     <= beat_d;
    end
  end

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    operand_word_reg u_reg (
      .clk    (clk),
      .resetn (resetn),
      .we_i   (op_we[i]),
      .idx_i  (widx),
      .data_i (in_data_i),
      .q_o    (op_q[i])
    );
  end

  assign exp_modulus_o  = op_q[SEL_MOD];
  assign exp_rmodm_o    = op_q[SEL_RM];
  assign exp_r2modm_o   = op_q[SEL_R2];
  assign exp_exponent_o = op_q[SEL_EXP];
  assign exp_x_o        = op_q[SEL_X];

  assign go_err_o    = go_err_q;
  assign busy_o      = (state_q != StIdle);
  assign loaded_o    = loaded_q;
  assign exp_start_o = (state_q == StStart);
  assign exp_mult_o  = exp_mult_q;
  assign out_valid_o = (state_q == StDrain);
  assign out_data_o  = shift_q[WORD_W-1:0];
  assign out_last_o  = (state_q == StDrain) && (beat_q == CNT_W'(WORDS - 1));

endmodule

// File: tb/tb_exp_operand_sequencer.sv
// Directed bench for exp_operand_sequencer; result words checked via a scoreboard queue.
module tb_exp_operand_sequencer;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_sel;
  logic [31:0]  in_data;
  logic         go;
  logic         go_mult;
  logic         go_err;
  logic         busy;
  logic [4:0]   loaded;
  logic         exp_start;
  logic         exp_mult;
  logic [511:0] exp_modulus, exp_rmodm, exp_r2modm, exp_exponent, exp_x;
  logic         exp_done;
  logic [511:0] exp_result;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  exp_operand_sequencer dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_sel_i       (in_sel),
    .in_data_i      (in_data),
    .go_i           (go),
    .go_mult_i      (go_mult),
    .go_err_o       (go_err),
    .busy_o         (busy),
    .loaded_o       (loaded),
    .exp_start_o    (exp_start),
    .exp_mult_o     (exp_mult),
    .exp_modulus_o  (exp_modulus),
    .exp_rmodm_o    (exp_rmodm),
    .exp_r2modm_o   (exp_r2modm),
    .exp_exponent_o (exp_exponent),
    .exp_x_o        (exp_x),
    .exp_done_i     (exp_done),
    .exp_result_i   (exp_result),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_last_o     (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic chk_w(input string tag, input logic [511:0] obs, input logic [511:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic load(input logic [2:0] sel, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = base + 32'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run(input logic mult, input logic [31:0] base, input logic stall);
    logic [511:0] res;
    logic [31:0]  w;
    int beats;
    int budget;
    logic stalled;
    go = 1'b1;
    go_mult = mult;
    tick();
    go = 1'b0;
    go_mult = 1'b0;
    chk("start_pulse", 32'(exp_start), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_mult", 32'(exp_mult), 32'(mult));
    chk("start_go_err", 32'(go_err), 32'd0);
    tick();
    chk("wait_start_low", 32'(exp_start), 32'd0);
    chk("wait_in_ready", 32'(in_ready), 32'd0);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("wait_go_ignored", 32'(go_err), 32'd0);
    chk("wait_no_restart", 32'(exp_start), 32'd0);
    chk("wait_mult_held", 32'(exp_mult), 32'(mult));
    chk("wait_no_out", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      res[i*32 +: 32] = base + 32'(i);
      sb_q.push_back(base + 32'(i));
    end
    exp_result = res;
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    exp_result = '0;
    beats = 0;
    budget = 0;
    stalled = 1'b0;
    out_ready = 1'b1;
    while (beats < 16 && budget < 200) begin
      budget++;
      if (out_valid) begin
        if (stall && beats == 3 && !stalled) begin
          stalled = 1'b1;
          out_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            tick();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, base + 32'd3);
            chk("stall_last", 32'(out_last), 32'd0);
          end
          out_ready = 1'b1;
        end
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          w = sb_q.pop_front();
          chk("out_data", out_data, w);
        end
        chk("out_last", 32'(out_last), 32'(beats == 15));
        beats++;
      end
      tick();
    end
    out_ready = 1'b0;
    chk("drain_beats", 32'(beats), 32'd16);
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_valid_low", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0;
    in_sel = 3'd0;
    in_data = '0;
    go = 1'b0;
    go_mult = 1'b0;
    exp_done = 1'b0;
    exp_result = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_exp_start", 32'(exp_start), 32'd0);
    chk("rst_exp_mult", 32'(exp_mult), 32'd0);
    chk("rst_go_err", 32'(go_err), 32'd0);
    chk_w("rst_exp_x", exp_x, 512'd0);
    resetn = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // x = words 1..16
    load(3'd4, 32'd1, 16);
    chk("x_word0", exp_x[31:0], 32'd1);
    chk("x_word15", exp_x[511:480], 32'd16);
    chk("x_loaded", 32'(loaded), 32'h10);

    // Mult-mode operands only: exponentiation go must be rejected
    load(3'd0, 32'h100, 16);
    load(3'd2, 32'h200, 16);
    chk("mult_set_loaded", 32'(loaded), 32'h15);
    go = 1'b1;
    go_mult = 1'b0;
    tick();
    go = 1'b0;
    chk("go_err_pulse", 32'(go_err), 32'd1);
    chk("go_err_no_start", 32'(exp_start), 32'd0);
    chk("go_err_idle", 32'(busy), 32'd0);
    tick();
    chk("go_err_one_cycle", 32'(go_err), 32'd0);

    run(1'b1, 32'hB0, 1'b1);

    // Full set, exponentiation mode
    load(3'd1, 32'h300, 16);
    load(3'd3, 32'h400, 16);
    chk("all_loaded", 32'(loaded), 32'h1F);
    chk("rmodm_word15", exp_rmodm[511:480], 32'h30F);
    chk("exponent_word0", exp_exponent[31:0], 32'h400);
    run(1'b0, 32'hA0, 1'b0);
    chk("loaded_retained", 32'(loaded), 32'h1F);

    // Selector change mid-operand
    load(3'd0, 32'h500, 7);
    load(3'd1, 32'h55, 1);
    chk("switch_loaded", 32'(loaded), 32'h1C);
    chk("switch_rmodm_w0", exp_rmodm[31:0], 32'h55);
    chk("switch_mod_w6", exp_modulus[223:192], 32'h506);
    load(3'd1, 32'h56, 15);
    chk("switch_rmodm_done", 32'(loaded), 32'h1E);
    chk("switch_rmodm_w15", exp_rmodm[511:480], 32'h64);

    // Illegal selector beat is dropped without advancing the count
    load(3'd5, 32'hDEAD, 1);
    chk("illegal_loaded", 32'(loaded), 32'h1E);
    load(3'd0, 32'h600, 15);
    chk("mod_15_beats", 32'(loaded), 32'h1E);
    load(3'd0, 32'h60F, 1);
    chk("mod_16_beats", 32'(loaded), 32'h1F);
    chk("mod_word0", exp_modulus[31:0], 32'h600);
    chk("mod_word15", exp_modulus[511:480], 32'h60F);

    // Reset while waiting on the core
    go = 1'b1;
    go_mult = 1'b0;
    tick();
    go = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    tick();
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_loaded", 32'(loaded), 32'd0);
    chk("wrst_out_valid", 32'(out_valid), 32'd0);
    chk("wrst_in_ready", 32'(in_ready), 32'd0);
    chk_w("wrst_modulus", exp_modulus, 512'd0);
    resetn = 1'b1;
    exp_result = {16{32'hEE}};
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    chk("late_done_ignored", 32'(out_valid), 32'd0);
    chk("late_done_idle", 32'(busy), 32'd0);
    chk("late_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("late_done_still_idle", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
